// File: rtl/beat_pkg.sv
// Shared types, default parameters and the radius profile for the beat pulse tracker.
package beat_pkg;

    typedef enum logic {S_IDLE, S_ANIM} state_e;
    typedef enum logic {MODE_PREV, MODE_AVG} mode_e;

    localparam int DEF_N_BANDS   = 16;
    localparam int DEF_BAND_W    = 4;
    localparam int DEF_WIN       = 3;
    localparam int DEF_N_WIN     = 10;
    localparam int DEF_THRESH    = 5;
    localparam int DEF_AVG_SHIFT = 3;
    localparam int DEF_ANIM_LEN  = 16;
    localparam int DEF_R_MAX     = 31;
    localparam int DEF_R_W       = 5;

    // Fast two-step expansion, then a linear shrink of 2 per frame down to 0.
    function automatic int radius_of(input int phase, input int r_max);
        if (phase == 0) return 0;
        if (phase == 1) return r_max / 3;
        if (phase == 2) return (2 * r_max) / 3;
        if (r_max - 2 * phase < 0) return 0;
        return r_max - 2 * phase;
    endfunction

endpackage

// File: rtl/band_window_sum.sv
// Combinational sliding-window band sums: window k covers bands k..k+WIN-1.
module band_window_sum #(
    parameter int N_BANDS = 16,
    parameter int BAND_W  = 4,
    parameter int WIN     = 3,
    parameter int N_WIN   = 10
) (
    input  logic [N_BANDS*BAND_W-1:0]                   data,
    output logic [N_WIN*(BAND_W+$clog2(WIN))-1:0]       sums
);
    localparam int SUM_W = BAND_W + $clog2(WIN);

    // Bands above the last window are legitimately ignored.
    logic unused_bands;
    assign unused_bands = ^data;

    for (genvar k = 0; k < N_WIN; k++) begin : g_win
        logic [SUM_W-1:0] s;
        always_comb begin
            s = '0;
            for (int b = 0; b < WIN; b++) begin
                s = s + SUM_W'(data[(k+b)*BAND_W +: BAND_W]);
            end
        end
        assign sums[k*SUM_W +: SUM_W] = s;
    end

endmodule

// File: rtl/beat_pulse_tracker.sv
// Spectrum beat detector driving a frame-paced pulse/radius animation.
//   state  | meaning
//   S_IDLE | phase 0, waiting for a window energy rise
//   S_ANIM | phase 1..ANIM_LEN-1, animation running, triggers ignored
module beat_pulse_tracker
    import beat_pkg::*;
#(
    parameter int N_BANDS   = DEF_N_BANDS,
    parameter int BAND_W    = DEF_BAND_W,
    parameter int WIN       = DEF_WIN,
    parameter int N_WIN     = DEF_N_WIN,
    parameter int THRESH    = DEF_THRESH,
    parameter int AVG_SHIFT = DEF_AVG_SHIFT,
    parameter int ANIM_LEN  = DEF_ANIM_LEN,
    parameter int R_MAX     = DEF_R_MAX,
    parameter int R_W       = DEF_R_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_frame_valid,
    input  logic [N_BANDS*BAND_W-1:0]    i_data,
    input  logic                         i_mode,
    output logic [$clog2(ANIM_LEN)-1:0]  o_phase,
    output logic [R_W-1:0]               o_radius,
    output logic                         o_beat_pulse,
    output logic [$clog2(N_WIN)-1:0]     o_beat_band,
    output logic [15:0]                  o_beat_cnt
);
    localparam int SUM_W = BAND_W + $clog2(WIN);
    localparam int ACC_W = SUM_W + AVG_SHIFT;
    localparam int PH_W  = $clog2(ANIM_LEN);
    localparam int BB_W  = $clog2(N_WIN);

    logic [N_WIN*SUM_W-1:0] sums;
    logic [SUM_W-1:0]       prev_q [N_WIN];
    logic [ACC_W-1:0]       acc_q  [N_WIN];
    logic                   primed_q;

    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_d;
    logic                   fire;
    logic                   hit_any;
    logic [BB_W-1:0]        hit_idx;
    logic [SUM_W-1:0]       ref_v;

    band_window_sum #(
        .N_BANDS (N_BANDS),
        .BAND_W  (BAND_W),
        .WIN     (WIN),
        .N_WIN   (N_WIN)
    ) u_sum (
        .data    (i_data),
        .sums    (sums)
    );

    // Descending scan so the lowest triggering window wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        ref_v   = '0;
        for (int k = N_WIN - 1; k >= 0; k--) begin
            ref_v = (mode_e'(i_mode) == MODE_AVG) ? SUM_W'(acc_q[k] >> AVG_SHIFT) : prev_q[k];
            if ({1'b0, sums[k*SUM_W +: SUM_W]} >= {1'b0, ref_v} + (SUM_W+1)'(THRESH)) begin
                hit_any = 1'b1;
                hit_idx = BB_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = o_phase;
        fire    = 1'b0;
        if (i_frame_valid && primed_q) begin
            case (state_q)
                S_IDLE: begin
                    if (hit_any) begin
                        state_d = S_ANIM;
                        phase_d = PH_W'(1);
                        fire    = 1'b1;
                    end
                end
                S_ANIM: begin
                    if (o_phase == PH_W'(ANIM_LEN - 1)) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = o_phase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            o_phase <= '0;
        end else begin
            state_q <= state_d;
            o_phase <= phase_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            primed_q     <= 1'b0;
            o_beat_pulse <= 1'b0;
            o_beat_band  <= '0;
            o_beat_cnt   <= '0;
            o_radius     <= '0;
            for (int k = 0; k < N_WIN; k++) begin
                prev_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            o_beat_pulse <= fire;
            o_radius     <= R_W'(radius_of(int'(o_phase), R_MAX));
            if (fire) begin
                o_beat_band <= hit_idx;
                o_beat_cnt  <= o_beat_cnt + 16'd1;
            end
            if (i_frame_valid) begin
                primed_q <= 1'b1;
                for (int k = 0; k < N_WIN; k++) begin
                    prev_q[k] <= sums[k*SUM_W +: SUM_W];
                    // First frame seeds the average at the current level to avoid a start-up ramp.
                    if (!primed_q)
                        acc_q[k] <= ACC_W'(sums[k*SUM_W +: SUM_W]) << AVG_SHIFT;
                    else
                        acc_q[k] <= acc_q[k] - (acc_q[k] >> AVG_SHIFT) + ACC_W'(sums[k*SUM_W +: SUM_W]);
                end
            end
        end
    end

endmodule

// File: tb/tb_beat_pulse_tracker.sv
// Randomized and directed bench for beat_pulse_tracker against a frame-level reference model.
module tb_beat_pulse_tracker;
    localparam int NB = 16, BW = 4, WIN = 3, NW = 10, TH = 5, SH = 3, AL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        mode = 1'b0;
    logic [63:0] data = '0;
    logic [3:0]  phase;
    logic [4:0]  radius;
    logic        pulse;
    logic [3:0]  band;
    logic [15:0] cnt;

    beat_pulse_tracker #(
        .N_BANDS(NB), .BAND_W(BW), .WIN(WIN), .N_WIN(NW), .THRESH(TH),
        .AVG_SHIFT(SH), .ANIM_LEN(AL), .R_MAX(31), .R_W(5)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_valid (valid),
        .i_data        (data),
        .i_mode        (mode),
        .o_phase       (phase),
        .o_radius      (radius),
        .o_beat_pulse  (pulse),
        .o_beat_band   (band),
        .o_beat_cnt    (cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rad_tab [16] = '{0, 10, 20, 25, 23, 21, 19, 17, 15, 13, 11, 9, 7, 5, 3, 1};

    int m_prev [NW];
    int m_acc  [NW];
    int m_phase = 0, m_rad = 0, m_band = 0, m_cnt = 0;
    bit m_pulse = 0, m_primed = 0;
    bit last_pulse = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Frame-level reference: one update per accepted frame.
    always @(posedge clk or negedge rst_n) begin
        int s [NW];
        int hit, rf;
        if (!rst_n) begin
            m_phase = 0; m_rad = 0; m_band = 0; m_cnt = 0; m_pulse = 0; m_primed = 0;
            for (int k = 0; k < NW; k++) begin m_prev[k] = 0; m_acc[k] = 0; end
        end else begin
            m_rad   = rad_tab[m_phase];
            m_pulse = 0;
            if (valid) begin
                for (int k = 0; k < NW; k++) begin
                    s[k] = 0;
                    for (int b = 0; b < WIN; b++) s[k] += int'(data[(k+b)*BW +: BW]);
                end
                if (!m_primed) begin
                    for (int k = 0; k < NW; k++) begin m_prev[k] = s[k]; m_acc[k] = s[k] * 8; end
                    m_primed = 1;
                end else begin
                    hit = -1;
                    for (int k = 0; k < NW; k++) begin
                        rf = mode ? (m_acc[k] / 8) : m_prev[k];
                        if (hit < 0 && s[k] >= rf + TH) hit = k;
                    end
                    if (m_phase == 0) begin
                        if (hit >= 0) begin
                            m_phase = 1; m_pulse = 1; m_band = hit; m_cnt = (m_cnt + 1) % 65536;
                        end
                    end else begin
                        m_phase = (m_phase + 1) % AL;
                    end
                    for (int k = 0; k < NW; k++) begin
                        m_prev[k] = s[k];
                        m_acc[k]  = m_acc[k] - m_acc[k] / 8 + s[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("phase",  int'(phase),  m_phase);
        chk("radius", int'(radius), m_rad);
        chk("pulse",  int'(pulse),  int'(m_pulse));
        chk("band",   int'(band),   m_band);
        chk("count",  int'(cnt),    m_cnt);
        chk("pulse_back_to_back", int'(pulse && last_pulse), 0);
        last_pulse = pulse;
    end

    function automatic logic [63:0] all_b(input int v);
        logic [63:0] d;
        for (int i = 0; i < NB; i++) d[i*BW +: BW] = 4'(v);
        return d;
    endfunction

    function automatic logic [63:0] setb(input logic [63:0] d0, input int i, input int v);
        logic [63:0] d;
        d = d0;
        d[i*BW +: BW] = 4'(v);
        return d;
    endfunction

    task automatic frame(input logic [63:0] d, input logic m);
        valid = 1'b1; data = d; mode = m;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_phase",  int'(phase),  0);
        chk("rst_radius", int'(radius), 0);
        chk("rst_pulse",  int'(pulse),  0);
        chk("rst_band",   int'(band),   0);
        chk("rst_count",  int'(cnt),    0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] d;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("init_count", int'(cnt), 0);
        chk("init_phase", int'(phase), 0);

        // Priming frame never fires, nor does an identical follow-up.
        frame(all_b(15), 1'b0);
        chk("prime_pulse", int'(pulse), 0);
        chk("prime_phase", int'(phase), 0);
        chk("prime_count", int'(cnt), 0);
        @(negedge clk);
        chk("prime_radius", int'(radius), 0);
        frame(all_b(15), 1'b0);
        chk("same_frame_pulse", int'(pulse), 0);

        // Basic beat and full animation.
        do_reset();
        frame(all_b(2), 1'b0);
        frame(setb(all_b(2), 4, 7), 1'b0);
        chk("beat_pulse", int'(pulse), 1);
        chk("beat_band", int'(band), 2);
        chk("beat_count", int'(cnt), 1);
        chk("beat_phase", int'(phase), 1);
        for (int j = 1; j < 16; j++) begin
            frame(all_b(2), 1'b0);
            chk("anim_radius", int'(radius), rad_tab[j]);
            chk("anim_phase", int'(phase), (j + 1) % 16);
        end
        @(negedge clk);
        chk("anim_end_radius", int'(radius), 0);

        // Threshold boundary: rise of 4 is quiet, rise of exactly 5 fires.
        do_reset();
        frame(all_b(2), 1'b0);
        frame(all_b(2), 1'b0);
        frame(setb(all_b(2), 0, 6), 1'b0);
        chk("rise4_pulse", int'(pulse), 0);
        frame(all_b(2), 1'b0);
        frame(setb(all_b(2), 0, 7), 1'b0);
        chk("rise5_pulse", int'(pulse), 1);
        chk("rise5_band", int'(band), 0);
        chk("rise5_count", int'(cnt), 1);

        // Refractory window.
        repeat (4) frame(all_b(2), 1'b0);
        chk("refr_phase5", int'(phase), 5);
        frame(setb(all_b(2), 0, 7), 1'b0);
        chk("refr_pulse", int'(pulse), 0);
        chk("refr_count", int'(cnt), 1);
        repeat (10) frame(all_b(2), 1'b0);
        chk("refr_idle", int'(phase), 0);
        frame(setb(all_b(2), 0, 7), 1'b0);
        chk("post_refr_pulse", int'(pulse), 1);
        chk("post_refr_count", int'(cnt), 2);

        // Average reference: step fires, slow ramp does not.
        do_reset();
        frame(all_b(2), 1'b1);
        repeat (40) frame(all_b(2), 1'b1);
        frame(setb(all_b(2), 0, 7), 1'b1);
        chk("ema_step_pulse", int'(pulse), 1);
        chk("ema_step_band", int'(band), 0);
        repeat (15) frame(all_b(2), 1'b1);
        repeat (40) frame(all_b(2), 1'b1);
        for (int v = 3; v <= 9; v++) repeat (4) frame(setb(all_b(2), 0, v), logic'(v[0]));
        chk("ramp_count", int'(cnt), 1);

        // Idle gap holds the animation; reset mid-animation abandons it.
        do_reset();
        frame(all_b(2), 1'b0);
        frame(setb(all_b(2), 0, 7), 1'b0);
        repeat (2) frame(all_b(2), 1'b0);
        repeat (100) @(negedge clk);
        chk("gap_phase", int'(phase), 3);
        chk("gap_radius", int'(radius), 25);
        repeat (4) frame(all_b(2), 1'b0);
        chk("pre_rst_phase", int'(phase), 7);
        do_reset();
        frame(setb(all_b(2), 0, 15), 1'b0);
        chk("rst_prime_pulse", int'(pulse), 0);
        chk("rst_prime_count", int'(cnt), 0);

        // Randomized traffic.
        do_reset();
        for (int it = 0; it < 4000; it++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < NB; i++) d[i*BW +: BW] = 4'($urandom_range(0, 4));
                if ($urandom_range(0, 3) == 0) d[$urandom_range(0, NB-1)*BW +: BW] = 4'($urandom_range(8, 15));
                if ($urandom_range(0, 7) == 0) mode = ~mode;
                valid = ($urandom_range(0, 3) != 0);
                data  = d;
                @(negedge clk);
                valid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
